writeback_stage: RTL and testbench
==================================

# writeback_stage

Final pipeline stage of the RISC-V core: accepts retiring instructions from the memory stage, aligns and extends load data, selects the writeback value, and drives the write port of the register file. The register file has a one-cycle registered read and read-before-write ordering, so this block also provides two forwarding ports that let decode supply values the register file cannot yet return. It also keeps a 64-bit retired-instruction counter.

## Interface
- No parameters.
- clock  in  1  core clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  memory-stage instruction present this cycle.
- in_reg_write  in  1  instruction writes rd.
- in_rd  in  5  destination register index.
- in_wb_sel  in  2  writeback source: 0 = ALU, 1 = load, 2 = PC+4, 3 = none.
- in_alu_result  in  32  ALU result.
- in_pc  in  32  instruction PC.
- in_load_data  in  32  raw aligned word from dmem.
- in_funct3  in  3  load width/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- in_addr_lo  in  2  byte offset of the load address, in_alu_result[1:0].
- rf_write_enable  out  1  register file write strobe.
- rf_addr_rd  out  5  register file write index.
- rf_data_rd  out  32  register file write data.
- fwd_wb_valid, fwd_wb_rd, fwd_wb_data  out  1/5/32  value being written this cycle.
- fwd_hold_valid, fwd_hold_rd, fwd_hold_data  out  1/5/32  value written on the previous edge.
- load_misaligned  out  1  sticky misaligned-load flag.
- instret  out  64  retired-instruction count.

## Operation
- Stage register: on each edge, if in_valid, capture the computed writeback value, rd, and write qualifier. Otherwise clear the entry valid. Every entry is presented for exactly one cycle; there is no stall path, and upstream withholds in_valid to stall.
- Write qualifier: in_reg_write & in_wb_sel != 3 & in_rd != 0 & not misaligned.
- Value select:
  - wb_sel 0 → in_alu_result.
  - wb_sel 2 → in_pc + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - wb_sel 1 → load extract:
    - lb/lbu: byte at in_addr_lo.
    - lh/lhu: halfword at in_addr_lo[1].
    - lw: full word.
    - lb/lh sign-extend to 32 bits; lbu/lhu zero-extend.
    - Other funct3 values are treated as lw.
- Misaligned load: wb_sel 1 with (lw and addr_lo != 0) or (lh/lhu and addr_lo[0] = 1).
  - The write is suppressed.
  - load_misaligned sets on the capturing edge and stays high until reset.
- rf_* outputs are driven directly from the stage register. rf_write_enable = entry valid & qualifier.
- Forwarding:
  - fwd_wb_* mirrors the rf_* outputs.
  - The hold register captures fwd_wb_* on every edge, so fwd_hold_valid = previous rf_write_enable.
  - Decode priority: fwd_wb over fwd_hold over register file data.
- instret increments by 1 on every edge that captures in_valid, including misaligned and non-writing instructions. It wraps modulo 2^64.

## Timing
- Instruction valid in cycle T:
  - rf_write_enable is high in T+1.
  - The register file commits at the end of T+1.
  - fwd_hold_* is valid in T+2.
  - instret shows the increment in T+1.
- Back-to-back in_valid gives one write per cycle. The same rd in consecutive cycles shows the newer value on fwd_wb and the older on fwd_hold.
- Reset:
  - All outputs are 0: rf_*, fwd_*, load_misaligned, instret.
  - A pending entry is dropped with no write. The hold register is cleared.
  - in_valid asserted together with reset is ignored and does not count.
- rd = 0 never produces rf_write_enable or any fwd_*_valid.

## Test plan
- ALU write: in_valid, wb_sel 0, rd 5, alu 0x12345678 → T+1 rf_write_enable=1, rf_addr_rd=5, rf_data_rd=0x12345678; T+2 fwd_hold_valid=1, fwd_hold_data=0x12345678; instret=1.
- Loads with in_load_data 0x80FF7F01:
  - lb, addr_lo 3 → 0xFFFFFF80.
  - lbu, addr_lo 3 → 0x00000080.
  - lh, addr_lo 2 → 0xFFFF80FF.
  - lhu, addr_lo 0 → 0x00007F01.
  - lw, addr_lo 0 → 0x80FF7F01.
- Misaligned: lw addr_lo 2, rd 7 → no write, load_misaligned=1 and stays high across later valid instructions, instret still increments; reset → load_misaligned=0.
- x0 and none: rd 0 with wb_sel 0, then rd 9 with wb_sel 3 → rf_write_enable stays 0 and fwd valids stay 0; instret=2.
- JAL link: wb_sel 2, pc 0xFFFFFFFC, rd 1 → rf_data_rd=0x00000000. Then back-to-back writes to rd 3 (0xA, then 0xB) → fwd_wb_data=0xB with fwd_hold_data=0xA in the same cycle.
- Reset mid-stream: in_valid in T, reset in T+1 → no write in T+2, all outputs 0 in T+2, instret=0.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: load alignment/extension, writeback value select, register file
// write port, two-level forwarding and retired-instruction counter.
module writeback_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_reg_write,
    input  logic [4:0]  in_rd,
    input  logic [1:0]  in_wb_sel,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_load_data,
    input  logic [2:0]  in_funct3,
    input  logic [1:0]  in_addr_lo,
    output logic        rf_write_enable,
    output logic [4:0]  rf_addr_rd,
    output logic [31:0] rf_data_rd,
    output logic        fwd_wb_valid,
    output logic [4:0]  fwd_wb_rd,
    output logic [31:0] fwd_wb_data,
    output logic        fwd_hold_valid,
    output logic [4:0]  fwd_hold_rd,
    output logic [31:0] fwd_hold_data,
    output logic        load_misaligned,
    output logic [63:0] instret
);

    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        write_qual;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_value;
    logic [31:0] wb_value;

    logic        stage_we;
    logic [4:0]  stage_rd;
    logic [31:0] stage_data;

    always_comb begin
        is_byte = (in_funct3[1:0] == 2'b00);
        is_half = (in_funct3[1:0] == 2'b01);
        // funct3 values that are neither byte nor half fall back to a word load
        is_word = !is_byte && !is_half;

        misaligned = (in_wb_sel == 2'd1) &&
                     ((is_word && (in_addr_lo != 2'd0)) || (is_half && in_addr_lo[0]));

        write_qual = in_reg_write && (in_wb_sel != 2'd3) && (in_rd != 5'd0) && !misaligned;

        load_byte = 8'h00;
        unique case (in_addr_lo)
            2'd0: load_byte = in_load_data[7:0];
            2'd1: load_byte = in_load_data[15:8];
            2'd2: load_byte = in_load_data[23:16];
            2'd3: load_byte = in_load_data[31:24];
        endcase
        load_half = in_addr_lo[1] ? in_load_data[31:16] : in_load_data[15:0];

        if (is_byte)
            load_value = {{24{load_byte[7] & ~in_funct3[2]}}, load_byte};
        else if (is_half)
            load_value = {{16{load_half[15] & ~in_funct3[2]}}, load_half};
        else
            load_value = in_load_data;

        wb_value = in_alu_result;
        unique case (in_wb_sel)
            2'd0: wb_value = in_alu_result;
            2'd1: wb_value = load_value;
            2'd2: wb_value = in_pc + 32'd4;
            2'd3: wb_value = in_alu_result;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stage_we        <= 1'b0;
            stage_rd        <= '0;
            stage_data      <= '0;
            fwd_hold_valid  <= 1'b0;
            fwd_hold_rd     <= '0;
            fwd_hold_data   <= '0;
            load_misaligned <= 1'b0;
            instret         <= '0;
        end else begin
            stage_we <= in_valid && write_qual;
            if (in_valid) begin
                stage_rd   <= in_rd;
                stage_data <= wb_value;
                instret    <= instret + 64'd1;
                if (misaligned)
                    load_misaligned <= 1'b1;
            end
            fwd_hold_valid <= fwd_wb_valid;
            fwd_hold_rd    <= fwd_wb_rd;
            fwd_hold_data  <= fwd_wb_data;
        end
    end

    always_comb begin
        rf_write_enable = stage_we;
        rf_addr_rd      = stage_rd;
        rf_data_rd      = stage_data;
        fwd_wb_valid    = stage_we;
        fwd_wb_rd       = stage_rd;
        fwd_wb_data     = stage_data;
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with hand-computed expected values.
module tb_writeback_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc;
    logic [31:0] in_load_data;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        rf_write_enable;
    logic [4:0]  rf_addr_rd;
    logic [31:0] rf_data_rd;
    logic        fwd_wb_valid;
    logic [4:0]  fwd_wb_rd;
    logic [31:0] fwd_wb_data;
    logic        fwd_hold_valid;
    logic [4:0]  fwd_hold_rd;
    logic [31:0] fwd_hold_data;
    logic        load_misaligned;
    logic [63:0] instret;

    int unsigned err_count = 0;
    int unsigned chk_count = 0;

    writeback_stage dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_reg_write(in_reg_write),
        .in_rd(in_rd), .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result), .in_pc(in_pc),
        .in_load_data(in_load_data), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .rf_write_enable(rf_write_enable), .rf_addr_rd(rf_addr_rd), .rf_data_rd(rf_data_rd),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .fwd_hold_valid(fwd_hold_valid), .fwd_hold_rd(fwd_hold_rd), .fwd_hold_data(fwd_hold_data),
        .load_misaligned(load_misaligned), .instret(instret)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] ld,
                         input logic [2:0] f3, input logic [1:0] lo);
        in_valid      = 1'b1;
        in_reg_write  = rw;
        in_rd         = rd;
        in_wb_sel     = sel;
        in_alu_result = alu;
        in_pc         = pc;
        in_load_data  = ld;
        in_funct3     = f3;
        in_addr_lo    = lo;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] exp;
    } load_vec_t;

    load_vec_t load_vecs[8];

    initial begin
        load_vecs[0] = '{3'b000, 2'd3, 32'hFFFFFF80};
        load_vecs[1] = '{3'b100, 2'd3, 32'h00000080};
        load_vecs[2] = '{3'b001, 2'd2, 32'hFFFF80FF};
        load_vecs[3] = '{3'b101, 2'd0, 32'h00007F01};
        load_vecs[4] = '{3'b010, 2'd0, 32'h80FF7F01};
        load_vecs[5] = '{3'b100, 2'd1, 32'h0000007F};
        load_vecs[6] = '{3'b000, 2'd2, 32'hFFFFFFFF};
        load_vecs[7] = '{3'b011, 2'd0, 32'h80FF7F01};

        reset = 1'b1;
        idle();
        in_reg_write = 1'b0; in_rd = '0; in_wb_sel = '0; in_alu_result = '0;
        in_pc = '0; in_load_data = '0; in_funct3 = '0; in_addr_lo = '0;
        // valid held during reset must not count
        issue(1'b1, 5'd2, 2'd0, 32'hDEAD, 32'h0, 32'h0, 3'b010, 2'd0);
        step();
        step();
        reset = 1'b0;
        idle();
        check_value("reset_we", rf_write_enable, 0);
        check_value("reset_addr", rf_addr_rd, 0);
        check_value("reset_data", rf_data_rd, 0);
        check_value("reset_hold_valid", fwd_hold_valid, 0);
        check_value("reset_misaligned", load_misaligned, 0);
        check_value("reset_instret", instret, 0);
        step();
        check_value("post_reset_instret", instret, 0);

        // ALU write and hold timing
        issue(1'b1, 5'd5, 2'd0, 32'h12345678, 32'h0, 32'h0, 3'b010, 2'd0);
        step();
        idle();
        check_value("alu_we", rf_write_enable, 1);
        check_value("alu_addr", rf_addr_rd, 5);
        check_value("alu_data", rf_data_rd, 32'h12345678);
        check_value("alu_fwd_wb", fwd_wb_data, 32'h12345678);
        check_value("alu_instret", instret, 1);
        step();
        check_value("alu_we_off", rf_write_enable, 0);
        check_value("alu_hold_valid", fwd_hold_valid, 1);
        check_value("alu_hold_rd", fwd_hold_rd, 5);
        check_value("alu_hold_data", fwd_hold_data, 32'h12345678);
        check_value("alu_instret2", instret, 1);

        // load extraction, back-to-back
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 5'd10, 2'd1, {30'h0, load_vecs[i].lo}, 32'h0, 32'h80FF7F01,
                  load_vecs[i].f3, load_vecs[i].lo);
            step();
            check_value($sformatf("load%0d_we", i), rf_write_enable, 1);
            check_value($sformatf("load%0d_data", i), rf_data_rd, load_vecs[i].exp);
        end
        idle();
        check_value("load_instret", instret, 9);
        check_value("load_no_misaligned", load_misaligned, 0);

        // misaligned word load
        issue(1'b1, 5'd7, 2'd1, 32'h2, 32'h0, 32'h80FF7F01, 3'b010, 2'd2);
        step();
        check_value("mis_we", rf_write_enable, 0);
        check_value("mis_flag", load_misaligned, 1);
        check_value("mis_instret", instret, 10);
        issue(1'b1, 5'd8, 2'd0, 32'h11, 32'h0, 32'h0, 3'b010, 2'd0);
        step();
        check_value("mis_after_we", rf_write_enable, 1);
        check_value("mis_sticky", load_misaligned, 1);
        // misaligned halfword
        issue(1'b1, 5'd9, 2'd1, 32'h1, 32'h0, 32'h80FF7F01, 3'b101, 2'd1);
        step();
        idle();
        check_value("mis_half_we", rf_write_enable, 0);
        check_value("mis_half_instret", instret, 12);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_value("mis_reset_flag", load_misaligned, 0);
        check_value("mis_reset_instret", instret, 0);

        // x0 and wb_sel none
        issue(1'b1, 5'd0, 2'd0, 32'h55, 32'h0, 32'h0, 3'b010, 2'd0);
        step();
        check_value("x0_we", rf_write_enable, 0);
        check_value("x0_fwd_valid", fwd_wb_valid, 0);
        issue(1'b1, 5'd9, 2'd3, 32'h66, 32'h0, 32'h0, 3'b010, 2'd0);
        step();
        idle();
        check_value("none_we", rf_write_enable, 0);
        check_value("none_hold_valid", fwd_hold_valid, 0);
        step();
        check_value("none_hold_valid2", fwd_hold_valid, 0);
        check_value("none_instret", instret, 2);

        // JAL link wrap, then same-rd back-to-back
        issue(1'b1, 5'd1, 2'd2, 32'h0, 32'hFFFFFFFC, 32'h0, 3'b010, 2'd0);
        step();
        check_value("jal_we", rf_write_enable, 1);
        check_value("jal_addr", rf_addr_rd, 1);
        check_value("jal_data", rf_data_rd, 32'h0);
        issue(1'b1, 5'd1, 2'd2, 32'h0, 32'h00000100, 32'h0, 3'b010, 2'd0);
        step();
        check_value("jal2_data", rf_data_rd, 32'h104);
        issue(1'b1, 5'd3, 2'd0, 32'hA, 32'h0, 32'h0, 3'b010, 2'd0);
        step();
        issue(1'b1, 5'd3, 2'd0, 32'hB, 32'h0, 32'h0, 3'b010, 2'd0);
        step();
        idle();
        check_value("b2b_wb_valid", fwd_wb_valid, 1);
        check_value("b2b_wb_rd", fwd_wb_rd, 3);
        check_value("b2b_wb_data", fwd_wb_data, 32'hB);
        check_value("b2b_hold_valid", fwd_hold_valid, 1);
        check_value("b2b_hold_rd", fwd_hold_rd, 3);
        check_value("b2b_hold_data", fwd_hold_data, 32'hA);
        check_value("b2b_instret", instret, 6);

        // reset mid-stream drops the pending entry
        step();
        issue(1'b1, 5'd4, 2'd0, 32'h55, 32'h0, 32'h0, 3'b010, 2'd0);
        step();
        idle();
        check_value("mid_we_t1", rf_write_enable, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_value("mid_we", rf_write_enable, 0);
        check_value("mid_data", rf_data_rd, 0);
        check_value("mid_addr", rf_addr_rd, 0);
        check_value("mid_hold_valid", fwd_hold_valid, 0);
        check_value("mid_hold_data", fwd_hold_data, 0);
        check_value("mid_instret", instret, 0);

        $display("Result: errors=%0d of %0d checks", err_count, chk_count);
        $finish;
    end

endmodule
